// File: rtl/inpdt_accum_4p.sv
// Four-lane zero-point-corrected inner-product engine. Produces four
// consecutive VEC_LEN-element partial sums plus a captured bias byte and
// holds them until the downstream quantize stage acknowledges.
module inpdt_accum_4p #(
    parameter logic [7:0] ZERO_DATA = 8'd128,
    parameter logic [7:0] ZERO_W    = 8'd128,
    parameter int         VEC_LEN   = 32,
    parameter int         BEAT_W    = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [7:0]  bias_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] data_word,
    input  logic [31:0] w_word,
    output logic [31:0] inpdt_R_reg,
    output logic [31:0] inpdt_Rtemp1_reg,
    output logic [31:0] inpdt_Rtemp2_reg,
    output logic [31:0] inpdt_Rtemp3_reg,
    output logic [7:0]  bias_buffer,
    output logic        out_valid,
    input  logic        out_ack
);
    localparam int NUM_LANES = 4;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(VEC_LEN / NUM_LANES - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t                     state_q, state_d;
    logic [31:0]                acc_q, acc_d;
    logic [BEAT_W-1:0]          beat_q, beat_d;
    logic [1:0]                 slot_q, slot_d;
    logic [3:0][31:0]           part_q, part_d;
    logic [7:0]                 bias_q, bias_d;
    logic                       out_valid_q, out_valid_d;
    logic                       in_ready_q, in_ready_d;
    logic [NUM_LANES-1:0][31:0] term;
    logic [31:0]                acc_sum;

    // Per-lane zero-point removal and 9x9 signed multiply, sign-extended to 32b
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic signed [8:0]  dx, dw;
        logic signed [17:0] prod;
        assign dx      = $signed({1'b0, data_word[8*g +: 8]}) - $signed({1'b0, ZERO_DATA});
        assign dw      = $signed({1'b0, w_word[8*g +: 8]})    - $signed({1'b0, ZERO_W});
        assign prod    = dx * dw;
        assign term[g] = {{14{prod[17]}}, prod};
    end

    // Running sum including this beat's four lane products (wraps mod 2^32)
    always_comb begin
        acc_sum = acc_q;
        for (int i = 0; i < NUM_LANES; i++) acc_sum = acc_sum + term[i];
    end

    // Next-state and datapath update for IDLE -> ACCUM -> HOLD sequencing
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        beat_d  = beat_q;
        slot_d  = slot_q;
        part_d  = part_q;
        bias_d  = bias_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bias_d  = bias_in;
                    acc_d   = '0;
                    beat_d  = '0;
                    slot_d  = '0;
                    part_d  = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid && in_ready_q) begin
                    if (beat_q == LAST_BEAT) begin
                        part_d[slot_q] = acc_sum;
                        acc_d          = '0;
                        beat_d         = '0;
                        slot_d         = slot_q + 2'd1;
                        if (slot_q == 2'd3) state_d = HOLD;
                    end else begin
                        acc_d  = acc_sum;
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Handshake flags are registered copies of the upcoming state
        in_ready_d  = (state_d == ACCUM);
        out_valid_d = (state_d == HOLD);
    end

    // State and result registers; async reset clears everything
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            beat_q      <= '0;
            slot_q      <= '0;
            part_q      <= '0;
            bias_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            beat_q      <= beat_d;
            slot_q      <= slot_d;
            part_q      <= part_d;
            bias_q      <= bias_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready         = in_ready_q;
    assign out_valid        = out_valid_q;
    assign inpdt_R_reg      = part_q[0];
    assign inpdt_Rtemp1_reg = part_q[1];
    assign inpdt_Rtemp2_reg = part_q[2];
    assign inpdt_Rtemp3_reg = part_q[3];
    assign bias_buffer      = bias_q;

endmodule

// File: doc/inpdt_accum_4p.md
Name: inpdt_accum_4p

Overview:
- Fixed-point inner-product engine that produces the four 32-bit partial inner products (inpdt_R_reg, inpdt_Rtemp1_reg..inpdt_Rtemp3_reg) and the 8-bit bias_buffer.
- These are consumed by the gate bias-add/quantize/saturate stage.
- It streams packed 8-bit data and weight words, removes zero points, and multiply-accumulates. It then holds the results stable until the downstream stage acknowledges them.

Parameters:
- ZERO_DATA, 8'd128, zero point of data bytes (Xt/Ht).
- ZERO_W, 8'd128, zero point of weight bytes.
- VEC_LEN, 32, elements per partial sum. Must be a multiple of 4 and at least 4.
- BEAT_W, 8, width of the beat counter. Must satisfy 2^BEAT_W >= VEC_LEN/4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  begins a new 4-partial computation; accepted only in IDLE.
- bias_in  in  8  bias byte; captured on an accepted start.
- in_valid  in  1  data_word/w_word beat valid.
- in_ready  out  1  engine accepts a beat this cycle.
- data_word  in  32  4 packed unsigned data bytes; lane i = bits [8i+7:8i].
- w_word  in  32  4 packed unsigned weight bytes, same lane order.
- inpdt_R_reg  out  32  partial 0 (signed).
- inpdt_Rtemp1_reg  out  32  partial 1 (signed).
- inpdt_Rtemp2_reg  out  32  partial 2 (signed).
- inpdt_Rtemp3_reg  out  32  partial 3 (signed).
- bias_buffer  out  8  captured bias.
- out_valid  out  1  all four partials and bias_buffer are valid and stable.
- out_ack  in  1  consumer has taken the results.

Behaviour:
- Reset (rstn low, asynchronous): state is IDLE. The following are all 0: the four partial outputs, bias_buffer, accumulator, beat counter, slot counter, out_valid and in_ready.
- States are IDLE, ACCUM and HOLD.
- IDLE:
  - in_ready=0, out_valid=0.
  - On start=1 at a clock edge: bias_buffer<=bias_in; accumulator, beat counter and slot counter <=0; the four partial outputs <=0; next state ACCUM.
- ACCUM:
  - in_ready=1. A beat transfers on a clock edge with in_valid&&in_ready.
  - Per lane i: term_i = ($signed({1'b0,x_i}) - ZERO_DATA) * ($signed({1'b0,w_i}) - ZERO_W).
  - Each difference is 9-bit signed; each product is sign-extended to 32 bits.
  - acc_next = acc + term_0 + term_1 + term_2 + term_3, in two's complement modulo 2^32 (wrap, no saturation).
  - The beat counter increments on each transfer. On the transfer that completes VEC_LEN/4 beats:
    - acc_next is written to the slot selected by the slot counter (0=R, 1=Rtemp1, 2=Rtemp2, 3=Rtemp3);
    - the accumulator and beat counter clear;
    - the slot counter increments.
  - Beats with in_valid=0 leave all state unchanged (gaps are allowed anywhere).
  - The write of slot 3 moves the state to HOLD.
- HOLD:
  - in_ready=0, out_valid=1.
  - All outputs are stable.
  - out_ack=1 at a clock edge moves the state to IDLE. out_valid drops the next cycle. Partial outputs and bias_buffer keep their values until the next accepted start.
- Latency: out_valid rises in the cycle after the edge that accepted the final (4*VEC_LEN/4-th) beat. A full run with no gaps takes VEC_LEN beats plus the start cycle.
- start outside IDLE is ignored. This includes start together with out_ack in HOLD: the engine goes to IDLE, and a start must be reasserted there.
- out_ack outside HOLD is ignored.
- in_valid outside ACCUM is ignored; no beat is consumed because in_ready=0.
- rstn asserted mid-ACCUM or mid-HOLD aborts immediately to reset values. No partial results survive.
- Registered outputs only. There is no combinational path from in_valid, data_word or w_word to any output.

Test Plan (VEC_LEN=8, i.e. 2 beats per partial, 8 beats total):
1. start with bias_in=8'h11; 8 back-to-back beats, all data bytes 129, all weight bytes 130 -> each partial = 8*(1*2) = 32'd16; bias_buffer=8'h11; out_valid rises one cycle after beat 8 and stays high until out_ack.
2. All data bytes 0, all weight bytes 0 -> each product is 16384; each partial = 32'h00020000.
3. All data bytes 255, all weight bytes 0 -> each product is -16256; each partial = 32'hFFFE0400. Mixed check: slot-dependent data (partial k uses data byte 128+k, weight byte 129) -> partials 0, 8, 16, 24.
4. Repeat scenario 1 with in_valid low on alternate cycles and start pulsed during ACCUM -> identical results; the extra start has no effect; in_ready is 0 in IDLE and HOLD.
5. rstn pulsed low after beat 5 -> all outputs 0 immediately, state IDLE. A subsequent full run yields the scenario-1 values, with no contamination from the aborted run.
6. In HOLD, hold out_ack low for 10 cycles -> outputs stable and out_valid=1 throughout. Then out_ack and start together -> IDLE, start ignored; start next cycle begins a new run.
